// File: rtl/tlb_unit.sv
// MIPS32 joint TLB: tlbwi/tlbr/tlbp from the M stage plus registered inst/data lookups.
// Optional feature macro TLB_TLBWR_EN adds the tlbwr input and a Random register.
module tlb_unit #(
   parameter int TLBNUM = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  tlb_op,
   input  logic        stallM,
   input  logic        flushM,
`ifdef TLB_TLBWR_EN
   input  logic        tlbwr,
`endif
   input  logic [31:0] cp0_index,
   input  logic [31:0] cp0_entryhi,
   input  logic [31:0] cp0_entrylo0,
   input  logic [31:0] cp0_entrylo1,
   input  logic [31:0] cp0_pagemask,
   output logic [31:0] Index_out,
   output logic [31:0] EntryHi_out,
   output logic [31:0] EntryLo0_out,
   output logic [31:0] EntryLo1_out,
   output logic [31:0] PageMask_out,
   output logic        tlb_done,
   input  logic [31:0] inst_vaddr,
   input  logic        inst_req,
   output logic [31:0] inst_paddr,
   output logic        inst_miss,
   output logic        inst_invalid,
   input  logic [31:0] data_vaddr,
   input  logic        data_req,
   input  logic        data_we,
   output logic [31:0] data_paddr,
   output logic        data_miss,
   output logic        data_invalid,
   output logic        data_modified,
   output logic        lookup_vld
);
   localparam int IW = $clog2(TLBNUM);
   localparam logic [1:0] OP_TLBR  = 2'b01;
   localparam logic [1:0] OP_TLBP  = 2'b10;
   localparam logic [1:0] OP_TLBWI = 2'b11;

   logic [18:0] vpn2_r [TLBNUM];
   logic [7:0]  asid_r [TLBNUM];
   logic [11:0] mask_r [TLBNUM];
   logic        g_r    [TLBNUM];
   logic [19:0] pfn0_r [TLBNUM];
   logic [19:0] pfn1_r [TLBNUM];
   logic [2:0]  c0_r   [TLBNUM];
   logic [2:0]  c1_r   [TLBNUM];
   logic        d0_r   [TLBNUM];
   logic        d1_r   [TLBNUM];
   logic        v0_r   [TLBNUM];
   logic        v1_r   [TLBNUM];

   logic          op_fire_s;
   logic          wr_en_s;
   logic          tlbwr_fire_s;
   logic [IW-1:0] wr_idx_s;
   logic [IW-1:0] rd_idx_s;
   logic [IW:0]   probe_s;
   logic [IW:0]   inst_m_s;
   logic [IW:0]   data_m_s;
   logic [34:0]   inst_res_s;
   logic [34:0]   data_res_s;

   // Lowest matching index wins; result is {hit, index}.
   function automatic logic [IW:0] find_entry(input logic [18:0] vpn2, input logic [7:0] asid);
      logic [IW:0] res;
      res = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (vpn2_r[i] == vpn2 && (g_r[i] || asid_r[i] == asid)) begin
            res = {1'b1, IW'(i)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Result packing is {paddr, miss, invalid, modified}.
   function automatic logic [34:0] translate(input logic [31:0] va, input logic req,
                                             input logic we, input logic [IW:0] m);
      logic [34:0]   res;
      logic [19:0]   pfn;
      logic          v;
      logic          d;
      logic [IW-1:0] idx;
      idx = m[IW-1:0];
      pfn = va[12] ? pfn1_r[idx] : pfn0_r[idx];
      v   = va[12] ? v1_r[idx] : v0_r[idx];
      d   = va[12] ? d1_r[idx] : d0_r[idx];
      if (!req) begin
         res = '0;
      end else if (va[31:30] == 2'b10) begin
         res = {3'b000, va[28:0], 3'b000};
      end else if (!m[IW]) begin
         res = {32'h0000_0000, 3'b100};
      end else begin
         res = {pfn, va[11:0], 1'b0, !v, v && we && !d};
      end
      return res;
   endfunction

`ifdef TLB_TLBWR_EN
   logic [IW-1:0] random_r;

   // Random counts down every cycle and wraps to the top entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         random_r <= IW'(TLBNUM - 1);
      end else if (random_r == IW'(0)) begin
         random_r <= IW'(TLBNUM - 1);
      end else begin
         random_r <= random_r - IW'(1);
      end
   end

   assign tlbwr_fire_s = tlbwr && !stallM && !flushM;
`else
   assign tlbwr_fire_s = 1'b0;
`endif

   // Op qualification and write port selection; tlbwr overrides tlb_op.
   always_comb begin
      op_fire_s = (tlb_op != 2'b00) && !stallM && !flushM && !tlbwr_fire_s;
      wr_en_s   = tlbwr_fire_s || (op_fire_s && tlb_op == OP_TLBWI);
      rd_idx_s  = cp0_index[IW-1:0];
`ifdef TLB_TLBWR_EN
      wr_idx_s  = tlbwr_fire_s ? random_r : cp0_index[IW-1:0];
`else
      wr_idx_s  = cp0_index[IW-1:0];
`endif
   end

   // Match lookups for the probe and both translation ports.
   always_comb begin
      probe_s    = find_entry(cp0_entryhi[31:13], cp0_entryhi[7:0]);
      inst_m_s   = find_entry(inst_vaddr[31:13], cp0_entryhi[7:0]);
      data_m_s   = find_entry(data_vaddr[31:13], cp0_entryhi[7:0]);
      inst_res_s = translate(inst_vaddr, inst_req, 1'b0, inst_m_s);
      data_res_s = translate(data_vaddr, data_req, data_we, data_m_s);
   end

   // Entry storage: cleared on reset, one write per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TLBNUM; i++) begin
            vpn2_r[i] <= '0; asid_r[i] <= '0; mask_r[i] <= '0; g_r[i] <= 1'b0;
            pfn0_r[i] <= '0; pfn1_r[i] <= '0; c0_r[i] <= '0; c1_r[i] <= '0;
            d0_r[i] <= 1'b0; d1_r[i] <= 1'b0; v0_r[i] <= 1'b0; v1_r[i] <= 1'b0;
         end
      end else if (wr_en_s) begin
         vpn2_r[wr_idx_s] <= cp0_entryhi[31:13];
         asid_r[wr_idx_s] <= cp0_entryhi[7:0];
         mask_r[wr_idx_s] <= cp0_pagemask[24:13];
         g_r[wr_idx_s]    <= cp0_entrylo0[0] & cp0_entrylo1[0];
         pfn0_r[wr_idx_s] <= cp0_entrylo0[25:6];
         c0_r[wr_idx_s]   <= cp0_entrylo0[5:3];
         d0_r[wr_idx_s]   <= cp0_entrylo0[2];
         v0_r[wr_idx_s]   <= cp0_entrylo0[1];
         pfn1_r[wr_idx_s] <= cp0_entrylo1[25:6];
         c1_r[wr_idx_s]   <= cp0_entrylo1[5:3];
         d1_r[wr_idx_s]   <= cp0_entrylo1[2];
         v1_r[wr_idx_s]   <= cp0_entrylo1[1];
      end
   end

   // Op results for CP0; held until the next tlbr/tlbp.
   always_ff @(posedge clk) begin
      if (rst) begin
         tlb_done     <= 1'b0;
         Index_out    <= '0;
         EntryHi_out  <= '0;
         EntryLo0_out <= '0;
         EntryLo1_out <= '0;
         PageMask_out <= '0;
      end else begin
         tlb_done <= op_fire_s || tlbwr_fire_s;
         if (op_fire_s) begin
            case (tlb_op)
               OP_TLBR: begin
                  EntryHi_out  <= {vpn2_r[rd_idx_s], 5'b00000, asid_r[rd_idx_s]};
                  PageMask_out <= {7'b0000000, mask_r[rd_idx_s], 13'b0};
                  EntryLo0_out <= {6'b000000, pfn0_r[rd_idx_s], c0_r[rd_idx_s],
                                   d0_r[rd_idx_s], v0_r[rd_idx_s], g_r[rd_idx_s]};
                  EntryLo1_out <= {6'b000000, pfn1_r[rd_idx_s], c1_r[rd_idx_s],
                                   d1_r[rd_idx_s], v1_r[rd_idx_s], g_r[rd_idx_s]};
               end
               OP_TLBP: Index_out <= probe_s[IW] ? 32'(probe_s[IW-1:0]) : 32'h8000_0000;
               default: ;
            endcase
         end
      end
   end

   // Registered translation results, one cycle after the request.
   always_ff @(posedge clk) begin
      if (rst) begin
         lookup_vld    <= 1'b0;
         inst_paddr    <= '0;
         inst_miss     <= 1'b0;
         inst_invalid  <= 1'b0;
         data_paddr    <= '0;
         data_miss     <= 1'b0;
         data_invalid  <= 1'b0;
         data_modified <= 1'b0;
      end else begin
         lookup_vld <= inst_req || data_req;
         {inst_paddr, inst_miss, inst_invalid} <= inst_res_s[34:1];
         {data_paddr, data_miss, data_invalid, data_modified} <= data_res_s;
      end
   end

   logic unused_s;
   assign unused_s = ^{cp0_index[31:IW], cp0_entryhi[12:8], cp0_entrylo0[31:26],
                       cp0_entrylo1[31:26], cp0_pagemask[31:25], cp0_pagemask[12:0],
                       inst_res_s[0]};
endmodule
